// File: rtl/cnt_pkg.sv
// Shared encodings for the modulus counter: mode codes and FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cnt_pkg;

  localparam logic [1:0] MODE_WRAP     = 2'b00;
  localparam logic [1:0] MODE_SAT      = 2'b01;
  localparam logic [1:0] MODE_ONESHOT  = 2'b10;
  localparam logic [1:0] MODE_WRAP_ALT = 2'b11;  // reserved code, behaves as wrap

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Wrap covers both the nominal code and the reserved one.
  function automatic logic is_wrap(input logic [1:0] m);
    return (m == MODE_WRAP) || (m == MODE_WRAP_ALT);
  endfunction

endpackage

// File: rtl/cnt_next.sv
// Combinational next-count and terminal detect for one enabled step.
// Latency: zero (pure combinational).
// Backpressure: none; caller decides whether the step is taken.
module cnt_next
  import cnt_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] modv,
  input  logic             up,
  input  logic [1:0]       mode,
  output logic             term,
  output logic [WIDTH-1:0] nxt
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Terminal is the modulus when counting up and zero when counting down;
  // away from terminal the +/-1 can never leave the range [0, modv].
  always_comb begin
    term = up ? (cur == modv) : (cur == '0);
    nxt  = cur;
    if (!term) begin
      nxt = up ? (cur + ONE) : (cur - ONE);
    end else if (is_wrap(mode)) begin
      nxt = up ? '0 : modv;
    end
  end

endmodule

// File: rtl/cnt_mod.sv
// Loadable up/down modulus counter with wrap, saturate and one-shot modes.
// Latency: one cycle from load/enable edge to registered dout/cout/done.
// Backpressure: none; every enabled edge is accepted unless a one-shot run is done.
module cnt_mod
  import cnt_pkg::*;
#(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] MOD_RST = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic             up,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] dout,
  output logic             cout,
  output logic             done
);

  state_e           state_q, state_nxt;
  logic [WIDTH-1:0] mod_q, mod_nxt;
  logic [WIDTH-1:0] dout_nxt;
  logic             cout_nxt;
  logic             done_nxt;
  logic             term;
  logic [WIDTH-1:0] step_val;

  cnt_next #(.WIDTH(WIDTH)) u_next (
    .cur  (dout),
    .modv (mod_q),
    .up   (up),
    .mode (mode),
    .term (term),
    .nxt  (step_val)
  );

  // Next state: load beats enable; a finished one-shot ignores enable.
  always_comb begin
    state_nxt = state_q;
    mod_nxt   = mod_q;
    dout_nxt  = dout;
    cout_nxt  = 1'b0;
    if (load) begin
      mod_nxt   = max;
      dout_nxt  = (data > max) ? max : data;
      state_nxt = ST_RUN;
    end else if (en && (state_q != ST_DONE)) begin
      dout_nxt = step_val;
      if (term) begin
        cout_nxt = 1'b1;
        if (mode == MODE_ONESHOT) begin
          state_nxt = ST_DONE;
        end
      end
    end
    done_nxt = (state_nxt == ST_DONE);
  end

  // State and output registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mod_q   <= MOD_RST;
      dout    <= '0;
      cout    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      mod_q   <= mod_nxt;
      dout    <= dout_nxt;
      cout    <= cout_nxt;
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_cnt_mod.sv
// Self-checking bench for cnt_mod: directed scenarios then randomized traffic.
// Latency: outputs checked 1 ns after each rising edge against a reference model.
// Backpressure: n/a.
module tb_cnt_mod;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en, load, up;
  logic [1:0]   mode;
  logic [W-1:0] data, max;
  logic [W-1:0] dout;
  logic         cout, done;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int m_mod, m_dout;
  bit m_cout, m_done;

  // Inputs as seen just before the rising edge.
  bit s_rst_n, s_en, s_load, s_up;
  int s_mode, s_data, s_max;

  cnt_mod #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .load  (load),
    .up    (up),
    .mode  (mode),
    .data  (data),
    .max   (max),
    .dout  (dout),
    .cout  (cout),
    .done  (done)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mod  = 65535;
    m_dout = 0;
    m_cout = 0;
    m_done = 0;
  endtask

  // Counter behaviour stated as plain arithmetic rules.
  task automatic model_edge();
    int term;
    if (!s_rst_n) begin
      model_reset();
    end else if (s_load) begin
      m_mod  = s_max;
      m_dout = (s_data > s_max) ? s_max : s_data;
      m_cout = 0;
      m_done = 0;
    end else if (s_en && !m_done) begin
      term = s_up ? m_mod : 0;
      if (m_dout != term) begin
        m_dout = s_up ? m_dout + 1 : m_dout - 1;
        m_cout = 0;
      end else begin
        m_cout = 1;
        if (s_mode == 1) begin
          // saturate: hold
        end else if (s_mode == 2) begin
          m_done = 1;
        end else begin
          m_dout = s_up ? 0 : m_mod;
        end
      end
    end else begin
      m_cout = 0;
    end
  endtask

  // One clock: snapshot inputs 1 ns before the edge, check 1 ns after it.
  task automatic tick();
    @(negedge clk);
    #9;
    s_rst_n = rst_n; s_en = en; s_load = load; s_up = up;
    s_mode = int'(mode); s_data = int'(data); s_max = int'(max);
    @(posedge clk);
    #1;
    model_edge();
    chk("model_dout", dout, m_dout);
    chk("model_cout", cout, m_cout);
    chk("model_done", done, m_done);
    checks++;
    assert (int'(dout) <= m_mod) else begin
      errors++;
      $error("FAIL dout_le_mod got=%0d exp<=%0d", dout, m_mod);
    end
  endtask

  task automatic do_load(input int d, input int mx, input int md, input bit u);
    load = 1'b1; en = 1'b0;
    data = W'(d); max = W'(mx); mode = 2'(md); up = u;
    tick();
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0; up = 1'b1;
    mode = 2'b00; data = '0; max = '0;
    model_reset();

    #5;
    chk("rst_dout", dout, 0);
    chk("rst_cout", cout, 0);
    chk("rst_done", done, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Count out of reset (IDLE counts), reach 5, then async reset between edges.
    en = 1'b1; up = 1'b1;
    repeat (5) tick();
    chk("pre_arst_dout", dout, 5);
    #4;
    rst_n = 1'b0;
    #1;
    chk("arst_dout", dout, 0);
    chk("arst_cout", cout, 0);
    chk("arst_done", done, 0);
    model_reset();
    #2;
    rst_n = 1'b1;

    // Up wrap: 8,9,0,1 with cout only on 0.
    do_load(8, 9, 0, 1'b1);
    chk("upw_0", dout, 8);
    en = 1'b1;
    tick(); chk("upw_1", dout, 9); chk("upw_c1", cout, 0);
    tick(); chk("upw_2", dout, 0); chk("upw_c2", cout, 1);
    tick(); chk("upw_3", dout, 1); chk("upw_c3", cout, 0);

    // Down wrap: 1,0,9,8 with cout only on 9.
    do_load(1, 9, 0, 1'b0);
    chk("dnw_0", dout, 1);
    en = 1'b1;
    tick(); chk("dnw_1", dout, 0); chk("dnw_c1", cout, 0);
    tick(); chk("dnw_2", dout, 9); chk("dnw_c2", cout, 1);
    tick(); chk("dnw_3", dout, 8); chk("dnw_c3", cout, 0);

    // Saturate: 2,3,3,3 with cout on every attempted step at 3.
    do_load(2, 3, 1, 1'b1);
    chk("sat_0", dout, 2);
    en = 1'b1;
    tick(); chk("sat_1", dout, 3); chk("sat_c1", cout, 0);
    tick(); chk("sat_2", dout, 3); chk("sat_c2", cout, 1);
    tick(); chk("sat_3", dout, 3); chk("sat_c3", cout, 1);

    // One-shot: single cout pulse, done sticks under enable until load.
    do_load(0, 2, 2, 1'b1);
    chk("os_0", dout, 0);
    en = 1'b1;
    tick(); chk("os_1", dout, 1);
    tick(); chk("os_2", dout, 2); chk("os_c2", cout, 0);
    tick(); chk("os_3", dout, 2); chk("os_c3", cout, 1); chk("os_d3", done, 1);
    tick(); chk("os_c4", cout, 0); chk("os_d4", done, 1);
    tick(); chk("os_d5", done, 1); chk("os_5", dout, 2);
    do_load(1, 2, 2, 1'b1);
    chk("os_reld", done, 0);
    chk("os_relv", dout, 1);

    // Modulus zero, down wrap: stays 0, every step is terminal.
    do_load(5, 0, 0, 1'b0);
    chk("m0_clamp", dout, 0);
    en = 1'b1;
    tick(); chk("m0_v", dout, 0); chk("m0_c", cout, 1);
    tick(); chk("m0_c2", cout, 1);

    // Clamp and load priority over enable.
    do_load(20, 9, 0, 1'b1);
    chk("clamp", dout, 9);
    load = 1'b1; en = 1'b1; data = W'(4); max = W'(9);
    tick();
    chk("ld_prio", dout, 4);
    load = 1'b0;

    // Enable toggling every 30 ns: only edges that see en=1 advance.
    do_load(0, 100, 0, 1'b1);
    en = 1'b1;
    fork
      begin
        repeat (5) begin
          #30;
          en = ~en;
        end
      end
    join_none
    repeat (9) tick();
    en = 1'b0;

    // Randomized traffic, including async reset and mid-count mode/up changes.
    for (int i = 0; i < 600; i++) begin
      int r;
      rst_n = ($urandom_range(0, 99) != 0);
      load  = ($urandom_range(0, 9) == 0);
      en    = ($urandom_range(0, 9) < 7);
      up    = 1'($urandom);
      mode  = 2'($urandom);
      data  = W'($urandom_range(0, 25));
      r     = $urandom_range(0, 5);
      case (r)
        0: max = W'(0);
        1: max = W'(1);
        2: max = W'(3);
        3: max = W'($urandom_range(0, 20));
        4: max = W'($urandom);
        default: max = W'($urandom_range(5, 12));
      endcase
      if (r == 4) data = W'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
